// File: rtl/hdmi_rx_capture_if.sv
// hdmi_rx_capture_if: write-side link between the capture stage and the pixel FIFO.
// master = capture stage (drives the word, strobe and start-of-frame flag),
// slave  = FIFO (drives its almost-full flag back).
interface hdmi_rx_capture_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] fifo_data_in;
   logic              fifo_write_enable;
   logic              fifo_sof;
   logic              fifo_full;

   modport master (
      output fifo_data_in,
      output fifo_write_enable,
      output fifo_sof,
      input  fifo_full
   );

   modport slave (
      input  fifo_data_in,
      input  fifo_write_enable,
      input  fifo_sof,
      output fifo_full
   );
endinterface

// File: rtl/hdmi_rx_capture.sv
// hdmi_rx_capture: pixel-capture stage between the TMDS decoder and the pixel FIFO.
// Waits for all three channels to be calibrated, skips FRAME_SKIP frames, aligns
// to a vsync edge, packs PIX_PER_WORD pixels per FIFO word (slot 0 in the LSBs),
// and on FIFO back-pressure drops the remainder of the frame instead of tearing it.
// Optional statistics counters: define HDMI_RX_CAPTURE_STATS_EN to build them;
// otherwise frame_count and drop_count read as zero.
module hdmi_rx_capture #(
   parameter int   CH_WIDTH     = 8,
   parameter int   PIX_PER_WORD = 1,
   parameter int   FRAME_SKIP   = 0,
   parameter logic VSYNC_POL    = 1'b1
) (
   input  logic                pclk,
   input  logic                reset_n,
   input  logic                hsync,
   input  logic                vsync,
   input  logic                de,
   input  logic                blue_vld,
   input  logic                green_vld,
   input  logic                red_vld,
   input  logic                blue_rdy,
   input  logic                green_rdy,
   input  logic                red_rdy,
   input  logic [CH_WIDTH-1:0] red,
   input  logic [CH_WIDTH-1:0] green,
   input  logic [CH_WIDTH-1:0] blue,
   input  logic                capture_en,
   hdmi_rx_capture_if.master   fifo,
   output logic                calibrated,
   output logic                overflow,
   output logic [15:0]         frame_count,
   output logic [15:0]         drop_count
);
   localparam int PIX_W  = 3 * CH_WIDTH;
   localparam int WORD_W = PIX_W * PIX_PER_WORD;
   localparam int IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PIX_PER_WORD - 1);

   typedef enum logic [1:0] {
      WAIT_CALIB = 2'd0,
      WAIT_FRAME = 2'd1,
      WRITE      = 2'd2,
      DROP       = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          skip_q, skip_d;
   logic [WORD_W-1:0]   pack_q, pack_d, word_s;
   logic [IDX_W-1:0]    slot_q, slot_d, slot_s;
   logic                arm_q, arm_d, arm_s;
   logic                vs_prev_q;
   logic [WORD_W-1:0]   data_q;
   logic                we_q, sof_q, cal_q, ovf_q;
   logic                cal_ok_s, vs_act_s, vs_edge_s;
   logic                cap_s, restart_s, wr_s, drop_s;
   logic                unused_hsync_s;

   // Lines are delimited by de alone, so hsync is deliberately ignored.
   assign unused_hsync_s = hsync;

   assign cal_ok_s  = blue_vld & green_vld & red_vld & blue_rdy & green_rdy & red_rdy;
   assign vs_act_s  = (vsync == VSYNC_POL);
   assign vs_edge_s = vs_act_s & ~vs_prev_q;

   // Next-state, skip counter and pixel packer; a restart begins a fresh word at slot 0.
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      pack_d    = pack_q;
      slot_d    = slot_q;
      arm_d     = arm_q;
      slot_s    = slot_q;
      arm_s     = arm_q;
      word_s    = '0;
      cap_s     = 1'b0;
      restart_s = 1'b0;
      wr_s      = 1'b0;
      drop_s    = 1'b0;
      if (!cal_ok_s) begin
         state_d = WAIT_CALIB;
         pack_d  = '0;
         slot_d  = '0;
         arm_d   = 1'b0;
      end else begin
         case (state_q)
            WAIT_CALIB: begin
               state_d = WAIT_FRAME;
               skip_d  = 4'(FRAME_SKIP);
            end
            WAIT_FRAME: begin
               if (vs_edge_s && capture_en) begin
                  if (skip_q != 4'd0) begin
                     skip_d = skip_q - 4'd1;
                  end else begin
                     state_d   = WRITE;
                     cap_s     = 1'b1;
                     restart_s = 1'b1;
                  end
               end else begin
                  state_d = WAIT_FRAME;
               end
            end
            WRITE: begin
               if (vs_edge_s) begin
                  if (capture_en) begin
                     cap_s     = 1'b1;
                     restart_s = 1'b1;
                  end else begin
                     state_d = WAIT_FRAME;
                     pack_d  = '0;
                     slot_d  = '0;
                  end
               end else begin
                  cap_s = 1'b1;
               end
            end
            DROP: begin
               if (vs_edge_s) begin
                  if (capture_en) begin
                     state_d   = WRITE;
                     cap_s     = 1'b1;
                     restart_s = 1'b1;
                  end else begin
                     state_d = WAIT_FRAME;
                  end
               end else begin
                  state_d = DROP;
               end
            end
            default: begin
               state_d = WAIT_CALIB;
            end
         endcase

         if (cap_s) begin
            if (restart_s) begin
               pack_d = '0;
               slot_s = '0;
               arm_s  = 1'b1;
            end else begin
               pack_d = pack_q;
               slot_s = slot_q;
               arm_s  = arm_q;
            end
            slot_d = slot_s;
            arm_d  = arm_s;
            if (de) begin
               pack_d[int'(slot_s) * PIX_W +: PIX_W] = {red, green, blue};
               if (slot_s == LAST_SLOT) begin
                  word_s = pack_d;
                  pack_d = '0;
                  slot_d = '0;
                  if (!fifo.fifo_full) begin
                     wr_s  = 1'b1;
                     arm_d = 1'b0;
                  end else begin
                     drop_s  = 1'b1;
                     state_d = DROP;
                  end
               end else begin
                  slot_d = slot_s + 1'b1;
               end
            end else begin
               slot_d = slot_s;
            end
         end else begin
            slot_s = slot_q;
         end
      end
   end

   // Control state, packer and vsync history registers.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= WAIT_CALIB;
         skip_q    <= 4'd0;
         pack_q    <= '0;
         slot_q    <= '0;
         arm_q     <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         pack_q    <= pack_d;
         slot_q    <= slot_d;
         arm_q     <= arm_d;
         vs_prev_q <= vs_act_s;
      end
   end

   // Registered FIFO write port and status flags; overflow is sticky until capture_en drops.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         we_q   <= 1'b0;
         sof_q  <= 1'b0;
         cal_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= wr_s ? word_s : data_q;
         we_q   <= wr_s;
         sof_q  <= wr_s & arm_s;
         cal_q  <= (state_d != WAIT_CALIB);
         if (!capture_en) begin
            ovf_q <= 1'b0;
         end else if (drop_s) begin
            ovf_q <= 1'b1;
         end else begin
            ovf_q <= ovf_q;
         end
      end
   end

   assign fifo.fifo_data_in      = data_q;
   assign fifo.fifo_write_enable = we_q;
   assign fifo.fifo_sof          = sof_q;
   assign calibrated             = cal_q;
   assign overflow               = ovf_q;

`ifdef HDMI_RX_CAPTURE_STATS_EN
   logic [15:0] frame_cnt_q, drop_cnt_q;

   // Saturating frame / dropped-word statistics, held clear while capture is disabled.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else if (!capture_en) begin
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         if (cal_ok_s && vs_edge_s && ((state_q == WRITE) || (state_q == DROP)) &&
             (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else begin
            frame_cnt_q <= frame_cnt_q;
         end
         if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end else begin
            drop_cnt_q <= drop_cnt_q;
         end
      end
   end

   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;
`else
   assign frame_count = 16'd0;
   assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hdmi_rx_capture.sv
// tb_hdmi_rx_capture: directed + randomized frames for hdmi_rx_capture
// (CH_WIDTH=8, PIX_PER_WORD=2, FRAME_SKIP=1). Expected FIFO words are derived per
// frame from the pixel list: consecutive pixel pairs, truncated at a full-FIFO drop.
module tb_hdmi_rx_capture;
   localparam int CH   = 8;
   localparam int PPW  = 2;
   localparam int SKIP = 1;
   localparam int WW   = 3 * CH * PPW;

`ifdef HDMI_RX_CAPTURE_STATS_EN
   localparam logic STATS = 1'b1;
`else
   localparam logic STATS = 1'b0;
`endif

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic          reset_n, hsync, vsync, de;
   logic          bv, gv, rv, br, gr, rr;
   logic [CH-1:0] red, green, blue;
   logic          capture_en, calibrated, overflow;
   logic [15:0]   fc, dc;

   hdmi_rx_capture_if #(.DATA_W(WW)) fifo_if ();

   hdmi_rx_capture #(
      .CH_WIDTH(CH), .PIX_PER_WORD(PPW), .FRAME_SKIP(SKIP), .VSYNC_POL(1'b1)
   ) dut (
      .pclk(pclk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .de(de),
      .blue_vld(bv), .green_vld(gv), .red_vld(rv),
      .blue_rdy(br), .green_rdy(gr), .red_rdy(rr),
      .red(red), .green(green), .blue(blue), .capture_en(capture_en),
      .fifo(fifo_if), .calibrated(calibrated), .overflow(overflow),
      .frame_count(fc), .drop_count(dc)
   );

   typedef struct {
      logic [WW-1:0] data;
      logic          sof;
      int            cyc;
   } wr_t;

   wr_t           got_q[$];
   wr_t           exp_q[$];
   logic [23:0]   px_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   logic          ov_model = 1'b0;

   // Record every FIFO write with the cycle it appeared in.
   always @(negedge pclk) begin
      if (fifo_if.fifo_write_enable === 1'b1)
         got_q.push_back('{data: fifo_if.fifo_data_in, sof: fifo_if.fifo_sof, cyc: cyc});
   end

   task automatic tick();
      @(posedge pclk);
      cyc++;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic rand_side();
      fifo_if.fifo_full = 1'($urandom_range(0, 1));
      hsync             = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_pix(input logic [23:0] p, input logic full);
      de                = 1'b1;
      {red, green, blue} = p;
      fifo_if.fifo_full = full;
      tick();
      de = 1'b0;
   endtask

   task automatic fill_rand(input int n);
      px_q.delete();
      for (int i = 0; i < n; i++) px_q.push_back(24'($urandom));
   endtask

   // One frame: vsync edge, then px_q with random gaps. full_w = index of the word whose
   // completing pixel sees fifo_full=1 (-1: none). capture=0 means no writes expected.
   task automatic frame(input int full_w, input bit edge_pix, input bit capture);
      int stamp[32];
      int i0;
      bit first;
      logic [WW-1:0] wd;
      int n;
      n = px_q.size();
      vsync = 1'b1;
      rand_side();
      if (edge_pix && n > 0) begin
         de = 1'b1;
         {red, green, blue} = px_q[0];
         i0 = 1;
      end else begin
         de = 1'b0;
         i0 = 0;
      end
      tick();
      de = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
         rand_side();
         tick();
      end
      vsync = 1'b0;
      for (int i = i0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            rand_side();
            tick();
         end
         if ((i % PPW) == PPW - 1)
            drive_pix(px_q[i], (i / PPW) == full_w);
         else
            drive_pix(px_q[i], 1'($urandom_range(0, 1)));
         stamp[i] = cyc;
      end
      rand_side();
      tick();
      tick();
      first = 1'b1;
      if (capture) begin
         for (int w = 0; w < n / PPW; w++) begin
            if (w == full_w) begin
               ov_model = 1'b1;
               break;
            end
            for (int k = 0; k < PPW; k++) wd[k*24 +: 24] = px_q[w*PPW + k];
            exp_q.push_back('{data: wd, sof: first, cyc: stamp[w*PPW + PPW - 1]});
            first = 1'b0;
         end
      end
      px_q.delete();
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
         chk({tag, "_sof"},  64'(got_q[i].sof),  64'(exp_q[i].sof));
         chk({tag, "_cyc"},  64'(got_q[i].cyc),  64'(exp_q[i].cyc));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int n, fw;
      logic [23:0] p0, p1;
      reset_n = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
      bv = 1'b0; gv = 1'b0; rv = 1'b0; br = 1'b0; gr = 1'b0; rr = 1'b0;
      red = 8'd0; green = 8'd0; blue = 8'd0; capture_en = 1'b1;
      fifo_if.fifo_full = 1'b0;
      repeat (3) tick();
      chk("rst_data", 64'(fifo_if.fifo_data_in), 64'd0);
      chk("rst_we", 64'(fifo_if.fifo_write_enable), 64'd0);
      chk("rst_sof", 64'(fifo_if.fifo_sof), 64'd0);
      chk("rst_cal", 64'(calibrated), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_fc", 64'(fc), 64'd0);
      chk("rst_dc", 64'(dc), 64'd0);

      // Red channel not ready: frames must be ignored.
      reset_n = 1'b1;
      bv = 1'b1; gv = 1'b1; rv = 1'b1; br = 1'b1; gr = 1'b1; rr = 1'b0;
      tick(); tick();
      fill_rand(4); frame(-1, 1'b0, 1'b0);
      fill_rand(4); frame(-1, 1'b0, 1'b0);
      chk("uncal_cal", 64'(calibrated), 64'd0);
      check_writes("uncal");
      rr = 1'b1;
      tick();
      chk("cal_rise", 64'(calibrated), 64'd1);
      tick();

      // One skipped frame, then the known pixel pair.
      fill_rand(4); frame(-1, 1'b0, 1'b0);
      px_q.push_back(24'h112233);
      px_q.push_back(24'h445566);
      frame(-1, 1'b0, 1'b1);
      check_writes("first_word");

      // FIFO full on the third word: drop rest of frame.
      fill_rand(6); frame(2, 1'b0, 1'b1);
      chk("ovf_set", 64'(overflow), 64'(ov_model));
      chk("drop_count", 64'(dc), STATS ? 64'd1 : 64'd0);
      check_writes("ovf");
      capture_en = 1'b0;
      tick();
      chk("ovf_clear", 64'(overflow), 64'd0);
      ov_model   = 1'b0;
      capture_en = 1'b1;
      tick();
      fill_rand(4); frame(-1, 1'b0, 1'b1);
      check_writes("resume");

      // Odd pixel count: trailing half word discarded at the next frame.
      fill_rand(3); frame(-1, 1'b0, 1'b1);
      check_writes("partial");
      fill_rand(4); frame(-1, 1'b1, 1'b1);
      check_writes("after_partial");

      // Randomized frames.
      repeat (12) begin
         n  = $urandom_range(0, 9);
         fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
         fill_rand(n);
         frame(fw, 1'($urandom_range(0, 1)), 1'b1);
         chk("rand_ovf", 64'(overflow), 64'(ov_model));
         check_writes("rand");
      end

      // Calibration glitch mid-line.
      vsync = 1'b1; de = 1'b0; tick(); vsync = 1'b0; tick();
      p0 = 24'($urandom); p1 = 24'($urandom);
      drive_pix(p0, 1'b0);
      drive_pix(p1, 1'b0);
      exp_q.push_back('{data: {p1, p0}, sof: 1'b1, cyc: cyc});
      drive_pix(24'($urandom), 1'b0);
      bv = 1'b0;
      drive_pix(24'($urandom), 1'b0);
      chk("calloss_we", 64'(fifo_if.fifo_write_enable), 64'd0);
      chk("calloss_cal", 64'(calibrated), 64'd0);
      bv = 1'b1;
      drive_pix(24'($urandom), 1'b0);
      drive_pix(24'($urandom), 1'b0);
      tick(); tick();
      check_writes("cal_loss");
      fill_rand(4); frame(-1, 1'b0, 1'b0);
      fill_rand(4); frame(-1, 1'b0, 1'b1);
      check_writes("cal_recover");

      // Reset during continuous writing; the word whose strobe is cut is never seen.
      vsync = 1'b1; de = 1'b0; tick(); vsync = 1'b0; tick();
      p0 = 24'($urandom); p1 = 24'($urandom);
      drive_pix(p0, 1'b0);
      drive_pix(p1, 1'b0);
      exp_q.push_back('{data: {p1, p0}, sof: 1'b1, cyc: cyc});
      drive_pix(24'($urandom), 1'b0);
      drive_pix(24'($urandom), 1'b0);
      chk("prerst_we", 64'(fifo_if.fifo_write_enable), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_we", 64'(fifo_if.fifo_write_enable), 64'd0);
      chk("midrst_data", 64'(fifo_if.fifo_data_in), 64'd0);
      chk("midrst_sof", 64'(fifo_if.fifo_sof), 64'd0);
      chk("midrst_cal", 64'(calibrated), 64'd0);
      chk("midrst_ovf", 64'(overflow), 64'd0);
      ov_model = 1'b0;
      repeat (3) drive_pix(24'($urandom), 1'b0);
      reset_n = 1'b1;
      repeat (4) drive_pix(24'($urandom), 1'b0);
      tick();
      check_writes("reset_mid");
      fill_rand(4); frame(-1, 1'b0, 1'b0);
      fill_rand(6); frame(-1, 1'b1, 1'b1);
      check_writes("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end
endmodule
